aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Parametrised AES key expansion engine for AES-128/192/256 (FIPS-197 §5.2), selectable per run.
//  Sits between key load and the round datapath. Generates one 32-bit word per cycle.
//  Stores all words and serves 128-bit round keys on a registered read port.
//  The cipher may start consuming keys while expansion is still running.
// PARAMETERS
//  MAX_KEY_BITS  256  largest key size supported (128|192|256); sizes the key port and the word store
//  MAX_WORDS     60   derived: 4*(Nr_max+1), giving 44/52/60
// PORTS
//  clk          in   1             single clock; all flops rise-edge
//  rst          in   1             asynchronous, active-low reset
//  start        in   1             one-cycle request to expand key/key_len
//  key_len      in   2             00=128, 01=192, 10=256, 11=reserved
//  key          in   MAX_KEY_BITS  left-aligned; key[MSB-:32] is w[0]
//  busy         out  1             expansion in progress
//  done         out  1             level: full schedule valid
//  cfg_err      out  1             one-cycle pulse: start rejected
//  rk_ready     out  4             number of complete round keys stored (words_written>>2)
//  rk_rd_en     in   1             round-key read request
//  rk_rd_idx    in   4             round key number r
//  rk_rd_data   out  128           {w[4r],w[4r+1],w[4r+2],w[4r+3]}; w[4r] in [127:96]
//  rk_rd_vld    out  1             one-cycle pulse, aligned with rk_rd_data
//  zeroize      in   1             only present with AES_KEXP_ZEROIZE_EN
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, cfg_err, rk_rd_vld=0; rk_ready=0; rk_rd_data=0. The word store is not reset.
//  FSM states: IDLE -> (start ok) EXPAND -> (last word) DONE -> (start ok) EXPAND. Optional WIPE state.
//  Per-mode values: Nk=4/6/8; Nr=10/12/14; total words T=4*(Nr+1).
//  Start acceptance: start is accepted in IDLE or DONE.
//   - On acceptance, the same edge captures key_len and writes w[0..Nk-1] from key.
//   - It sets idx=Nk, rk_ready=Nk>>2, rcon=0x01, done=0, busy=1.
//  Start is ignored while busy. It does not raise cfg_err in that case.
//  Start is rejected with a cfg_err pulse when key_len==11 or key size > MAX_KEY_BITS. State is unchanged.
//  EXPAND: each edge writes w[idx]=w[idx-Nk]^t, then idx++. t=w[idx-1], modified as follows:
//   - If idx mod Nk==0: t=SubWord(RotWord(t))^{rcon,24'h0}, then rcon=xtime(rcon).
//   - Else if Nk==8 and idx mod 8==4: t=SubWord(t).
//   - idx mod Nk comes from a wrap counter; no divider is used.
//   - 4 S-boxes are shared between both SubWord cases.
//  rk_ready updates on every edge that writes a word with idx[1:0]==3.
//  Completion: the edge that writes w[T-1] moves to DONE and sets busy=0, done=1.
//   - done rises 1+(T-Nk) cycles after the start edge: 41/47/53.
//  Read port: 1-cycle latency.
//   - If rk_rd_en and rk_rd_idx<rk_ready, the next edge sets rk_rd_data and rk_rd_vld=1.
//   - Otherwise the next edge sets rk_rd_vld=0 and rk_rd_data holds its value.
//   - A read of round key r during EXPAND returns valid data once r<rk_ready.
//  Read on the same edge a key completes: the read is evaluated against pre-edge rk_ready and misses. The requester retries.
//  Reset mid-EXPAND aborts the run: rk_ready=0 and stale words become unreadable.
// CONFIGURATION
//  AES_KEXP_ZEROIZE_EN defined:
//   - Adds the zeroize port and a WIPE state.
//   - zeroize has priority over start in any state.
//   - It clears busy, done and rk_ready, and sets busy=1 during the wipe.
//   - It writes 0 to one word per cycle for MAX_WORDS cycles, then enters IDLE with busy=0.
//   - start and reads are ignored during WIPE.
//  AES_KEXP_ZEROIZE_EN undefined: no zeroize port and no WIPE state. Words persist until overwritten.
// TESTING
//  AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
//   - done after 41 cycles; rk_ready=11.
//   - read idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//   - done after 47 cycles.
//   - read idx 12 -> e98ba06f448c773c8ecc720401002202.
//  AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   - done after 53 cycles.
//   - read idx 14 -> fe4890d1e6188d0b046df344706c631e.
//  Early read during AES-128 EXPAND:
//   - idx 1 at cycle 3 -> vld=0.
//   - idx 1 polled each cycle -> vld=1 with a0fafe1788542cb123a339392a6c7605.
//   - idx 11 after done -> vld=0.
//  Restart and rejected start:
//   - start with key_len=11 -> cfg_err pulse, state unchanged.
//   - start pulse while busy -> ignored.
//   - start from DONE with a new key -> done=0, rk_ready=1, new schedule correct.
//  Reset and zeroize:
//   - rst low at cycle 20 of EXPAND -> all outputs 0; next read idx 0 -> vld=0.
//   - with AES_KEXP_ZEROIZE_EN: zeroize after done -> busy for 60 cycles, then rk_ready=0.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key expansion: one schedule word per cycle into a word store, round keys served
// on a registered read port. Define AES_KEXP_ZEROIZE_EN to add the i_zeroize port and WIPE state.
module aes_key_expand #(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [1:0]              i_key_len,
  input  logic [MAX_KEY_BITS-1:0] i_key,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_cfg_err,
  output logic [3:0]              o_rk_ready,
  input  logic                    i_rk_rd_en,
  input  logic [3:0]              i_rk_rd_idx,
  output logic [127:0]            o_rk_rd_data,
  output logic                    o_rk_rd_vld
`ifdef AES_KEXP_ZEROIZE_EN
  ,
  input  logic                    i_zeroize
`endif
);

  localparam int unsigned NK_MAX    = MAX_KEY_BITS / 32;
  localparam int unsigned MAX_WORDS = 4 * (NK_MAX + 7);
  localparam int unsigned IDX_W     = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
`ifdef AES_KEXP_ZEROIZE_EN
    ,
    StWipe
`endif
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] r;
    y = gf_mul(a, a);
    r = y;
    for (int i = 0; i < 6; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] klen);
    case (klen)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] total_of(input logic [1:0] klen);
    case (klen)
      2'b00:   return IDX_W'(44);
      2'b01:   return IDX_W'(52);
      default: return IDX_W'(60);
    endcase
  endfunction

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [2:0]       r_mod, w_mod_nxt;
  logic [7:0]       r_rcon, w_rcon_nxt;
  logic [1:0]       r_klen, w_klen_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cfg_err, w_cfg_err_nxt;
  logic [3:0]       r_rk_ready, w_rk_ready_nxt;
  logic [127:0]     r_rd_data, w_rd_data_nxt;
  logic             r_rd_vld, w_rd_vld_nxt;

  logic [31:0]      r_words [MAX_WORDS];

  logic             w_start_ok, w_accept, w_exp_we, w_wipe_we, w_rd_hit;
  logic [3:0]       w_nk, w_nk_in;
  logic [IDX_W:0]   w_idx_p1;
  logic [31:0]      w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
  logic [IDX_W-1:0] w_rd_base;

  assign w_nk     = nk_of(r_klen);
  assign w_nk_in  = nk_of(i_key_len);
  assign w_idx_p1 = {1'b0, r_idx} + 1'b1;
  assign w_start_ok = (i_key_len != 2'b11) &&
                      ((32'd128 + 32'd64 * {30'd0, i_key_len}) <= MAX_KEY_BITS);

  // Both SubWord cases share one 4-S-box bank; only the input rotation differs.
  assign w_prev    = r_words[r_idx - IDX_W'(1)];
  assign w_back    = r_words[r_idx - IDX_W'(w_nk)];
  assign w_sub_in  = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_sub_out = sub_word(w_sub_in);
  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    end else if (w_nk == 4'd8 && r_mod == 3'd4) begin
      w_temp = w_sub_out;
    end
  end
  assign w_new = w_back ^ w_temp;

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mod_nxt      = r_mod;
    w_rcon_nxt     = r_rcon;
    w_klen_nxt     = r_klen;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_cfg_err_nxt  = 1'b0;
    w_rk_ready_nxt = r_rk_ready;
    w_accept       = 1'b0;
    w_exp_we       = 1'b0;
    w_wipe_we      = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          if (w_start_ok) begin
            w_accept       = 1'b1;
            w_state_nxt    = StExpand;
            w_klen_nxt     = i_key_len;
            w_idx_nxt      = IDX_W'(w_nk_in);
            w_mod_nxt      = 3'd0;
            w_rcon_nxt     = 8'h01;
            w_rk_ready_nxt = w_nk_in >> 2;
            w_busy_nxt     = 1'b1;
            w_done_nxt     = 1'b0;
          end else begin
            w_cfg_err_nxt  = 1'b1;
          end
        end
      end
      StExpand: begin
        w_exp_we  = 1'b1;
        w_idx_nxt = w_idx_p1[IDX_W-1:0];
        w_mod_nxt = ({1'b0, r_mod} == w_nk - 4'd1) ? 3'd0 : r_mod + 3'd1;
        if (r_mod == 3'd0) w_rcon_nxt = xtime(r_rcon);
        if (r_idx[1:0] == 2'b11) w_rk_ready_nxt = 4'(w_idx_p1 >> 2);
        if (r_idx == total_of(r_klen) - IDX_W'(1)) begin
          w_state_nxt = StDone;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
`ifdef AES_KEXP_ZEROIZE_EN
      StWipe: begin
        w_wipe_we = 1'b1;
        w_idx_nxt = w_idx_p1[IDX_W-1:0];
        if (r_idx == IDX_W'(MAX_WORDS - 1)) begin
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
        end
      end
`endif
      default: w_state_nxt = StIdle;
    endcase
`ifdef AES_KEXP_ZEROIZE_EN
    if (i_zeroize) begin
      w_state_nxt    = StWipe;
      w_idx_nxt      = '0;
      w_busy_nxt     = 1'b1;
      w_done_nxt     = 1'b0;
      w_rk_ready_nxt = 4'd0;
      w_cfg_err_nxt  = 1'b0;
      w_accept       = 1'b0;
      w_exp_we       = 1'b0;
      w_wipe_we      = 1'b0;
    end
`endif
  end

  // Read is checked against the pre-edge rk_ready, so a key completing on this edge misses.
  assign w_rd_base = IDX_W'({i_rk_rd_idx, 2'b00});
  always_comb begin
    w_rd_hit = i_rk_rd_en && (i_rk_rd_idx < r_rk_ready);
`ifdef AES_KEXP_ZEROIZE_EN
    if (r_state == StWipe) w_rd_hit = 1'b0;
`endif
    w_rd_vld_nxt  = w_rd_hit;
    w_rd_data_nxt = w_rd_hit ? {r_words[w_rd_base], r_words[w_rd_base + IDX_W'(1)],
                                r_words[w_rd_base + IDX_W'(2)], r_words[w_rd_base + IDX_W'(3)]}
                             : r_rd_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_mod      <= '0;
      r_rcon     <= 8'h01;
      r_klen     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_rk_ready <= 4'd0;
      r_rd_data  <= '0;
      r_rd_vld   <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_mod      <= w_mod_nxt;
      r_rcon     <= w_rcon_nxt;
      r_klen     <= w_klen_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
      r_rk_ready <= w_rk_ready_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_vld   <= w_rd_vld_nxt;
    end
  end

  // Word store is deliberately not reset; rk_ready gates what is readable.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int i = 0; i < NK_MAX; i++) begin
        if (i < int'(w_nk_in)) r_words[IDX_W'(i)] <= i_key[MAX_KEY_BITS-1-32*i -: 32];
      end
    end else if (w_exp_we) begin
      r_words[r_idx] <= w_new;
    end else if (w_wipe_we) begin
      r_words[r_idx] <= '0;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_cfg_err    = r_cfg_err;
  assign o_rk_ready   = r_rk_ready;
  assign o_rk_rd_data = r_rd_data;
  assign o_rk_rd_vld  = r_rd_vld;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-schedule vectors.
module tb_aes_key_expand;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy, done, cfg_err, rd_en, rd_vld;
  logic [3:0]   rk_ready, rd_idx;
  logic [127:0] rd_data;
`ifdef AES_KEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  int p;

  always #5 clk = ~clk;

  aes_key_expand #(.MAX_KEY_BITS(256)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_key_len    (key_len),
    .i_key        (key),
    .o_busy       (busy),
    .o_done       (done),
    .o_cfg_err    (cfg_err),
    .o_rk_ready   (rk_ready),
    .i_rk_rd_en   (rd_en),
    .i_rk_rd_idx  (rd_idx),
    .o_rk_rd_data (rd_data),
    .o_rk_rd_vld  (rd_vld)
`ifdef AES_KEXP_ZEROIZE_EN
    ,
    .i_zeroize    (zeroize)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic start_run(input logic [1:0] kl, input logic [255:0] k);
    start = 1'b1;
    key_len = kl;
    key = k;
    tick();
    start = 1'b0;
  endtask

  task automatic read_rk(input logic [3:0] idx);
    rd_en = 1'b1;
    rd_idx = idx;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_done(inout int cnt);
    while (!done && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_len = 2'b00;
    key = '0;
    rd_en = 1'b0;
    rd_idx = 4'd0;
`ifdef AES_KEXP_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_cfg_err", 128'(cfg_err), 128'd0);
    check("rst_rk_ready", 128'(rk_ready), 128'd0);
    check("rst_vld", 128'(rd_vld), 128'd0);
    check("rst_data", rd_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // AES-128 with early reads during expansion
    start_run(2'b00, {K128, 128'h0});
    n = 1;
    check("s128_busy", 128'(busy), 128'd1);
    check("s128_rk_ready", 128'(rk_ready), 128'd1);
    tick();
    tick();
    n = 3;
    rd_en = 1'b1;
    rd_idx = 4'd1;
    tick();
    n++;
    check("early_miss", 128'(rd_vld), 128'd0);
    p = 0;
    while (!rd_vld && p < 10) begin
      tick();
      p++;
    end
    n += p;
    rd_en = 1'b0;
    check("poll_edges", 128'(p), 128'd2);
    check("poll_data", rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_done(n);
    check("done128_lat", 128'(n), 128'd41);
    check("done128_rk", 128'(rk_ready), 128'd11);
    check("done128_busy", 128'(busy), 128'd0);
    read_rk(4'd10);
    check("rk128_10_vld", 128'(rd_vld), 128'd1);
    check("rk128_10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd11);
    check("rk128_11_vld", 128'(rd_vld), 128'd0);
    check("rk128_11_hold", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd0);
    check("rk128_0", rd_data, K128);
    read_rk(4'd2);
    check("rk128_2", rd_data, 128'hf2c295f27a96b9435935807a7359f67f);

    // Reserved key_len is rejected from DONE without disturbing state
    start_run(2'b11, {K128, 128'h0});
    check("rej_cfg_err", 128'(cfg_err), 128'd1);
    check("rej_done", 128'(done), 128'd1);
    check("rej_rk", 128'(rk_ready), 128'd11);
    tick();
    check("rej_pulse", 128'(cfg_err), 128'd0);

    // Restart from DONE with AES-192; a start while busy is ignored
    start_run(2'b01, {K192, 64'h0});
    n = 1;
    check("s192_done", 128'(done), 128'd0);
    check("s192_rk", 128'(rk_ready), 128'd1);
    while (n < 10) begin
      tick();
      n++;
    end
    start_run(2'b10, K256);
    n++;
    check("busy_start_err", 128'(cfg_err), 128'd0);
    wait_done(n);
    check("done192_lat", 128'(n), 128'd47);
    check("done192_rk", 128'(rk_ready), 128'd13);
    read_rk(4'd12);
    check("rk192_12", rd_data, 128'he98ba06f448c773c8ecc720401002202);
    read_rk(4'd0);
    check("rk192_0", rd_data, K192[191:64]);

    // AES-256: both initial round keys readable right after start
    start_run(2'b10, K256);
    n = 1;
    check("s256_rk", 128'(rk_ready), 128'd2);
    read_rk(4'd1);
    n++;
    check("rk256_1_vld", 128'(rd_vld), 128'd1);
    check("rk256_1", rd_data, K256[127:0]);
    wait_done(n);
    check("done256_lat", 128'(n), 128'd53);
    read_rk(4'd14);
    check("rk256_14", rd_data, 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset in the middle of an expansion
    start_run(2'b00, {K128, 128'h0});
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    check("mid_rst_rk", 128'(rk_ready), 128'd0);
    check("mid_rst_data", rd_data, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    read_rk(4'd0);
    check("post_rst_vld", 128'(rd_vld), 128'd0);

`ifdef AES_KEXP_ZEROIZE_EN
    start_run(2'b00, {K128, 128'h0});
    n = 1;
    wait_done(n);
    check("z_pre_done", 128'(n), 128'd41);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    p = 0;
    while (busy && p < 100) begin
      p++;
      tick();
    end
    check("z_busy_len", 128'(p), 128'd60);
    check("z_rk", 128'(rk_ready), 128'd0);
    check("z_done", 128'(done), 128'd0);
    read_rk(4'd0);
    check("z_read_vld", 128'(rd_vld), 128'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
